// File: rtl/serial_byte_loader.sv
// 8N1 serial receiver: deserialises rx into a byte presented as a data/enable
// pair for a downstream register; a low stop bit raises frame_error instead.
module serial_byte_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       enable,
  output logic       frame_error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_next;
  logic          rx_p0, rxs;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shreg, shreg_next;
  logic [7:0]    data_next;
  logic          enable_next, frame_error_next, busy_next;

  // Stage p0/p1: two-flop synchroniser, reset high so reset never fakes a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_p0 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rxs   <= rx_p0;
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data        <= '0;
      enable      <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      shreg       <= shreg_next;
      data        <= data_next;
      enable      <= enable_next;
      frame_error <= frame_error_next;
      busy        <= busy_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    idx_next         = idx;
    shreg_next       = shreg;
    data_next        = data;
    enable_next      = 1'b0;
    frame_error_next = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          idx_next = '0;
          // A start bit that is already high again at its centre was a glitch.
          state_next = rxs ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rxs, shreg[7:1]};
          if (idx == 3'd7) state_next = STOP;
          else             idx_next   = idx + 3'd1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            data_next   = shreg;
            enable_next = 1'b1;
            state_next  = IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = BREAK;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      BREAK: begin
        // Held-low line must return high before another start is recognised.
        cnt_next = '0;
        if (rxs) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: table-driven frames, hand-written corner
// sequences and random waveforms checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_serial_byte_loader;
  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] data;
  logic       enable, frame_error, busy;
  logic [7:0] reg_q;

  int n_checks = 0;
  int n_fail   = 0;

  serial_byte_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx),
    .data(data), .enable(enable), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Downstream 8-bit register fed by data/enable.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)    reg_q <= 8'h00;
    else if (enable) reg_q <= data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waveform: wq[j] is the rx level held during the clock period before edge j+1.
  bit wq[$];

  function automatic void add_level(bit v, int n);
    for (int i = 0; i < n; i++) wq.push_back(v);
  endfunction

  function automatic void add_frame(logic [7:0] b, bit stop);
    add_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) add_level(b[i], CPB);
    add_level(stop, CPB);
  endfunction

  // Reference timeline: rxs per cycle, expected outputs per cycle.
  int         n_cyc;
  bit         rxs_m[];
  bit         exp_en[], exp_fe[], exp_busy[];
  logic [7:0] exp_data[];

  function automatic bit rs(int k);
    if (k > n_cyc) return 1'b1;
    return rxs_m[k];
  endfunction

  function automatic void mark_busy(int a, int b);
    for (int k = a; k <= b && k <= n_cyc; k++) exp_busy[k] = 1'b1;
  endfunction

  function automatic void build_model();
    int t, t0, ts, sp, c;
    logic [7:0] b, cur;
    logic [7:0] ev_byte[];
    n_cyc    = wq.size();
    rxs_m    = new[n_cyc + 1];
    exp_en   = new[n_cyc + 1];
    exp_fe   = new[n_cyc + 1];
    exp_busy = new[n_cyc + 1];
    exp_data = new[n_cyc + 1];
    ev_byte  = new[n_cyc + 1];
    for (int k = 0; k <= n_cyc; k++) rxs_m[k] = (k < 2) ? 1'b1 : wq[k-2];
    t = 0;
    while (t <= n_cyc) begin
      t0 = t;
      while (t0 <= n_cyc && rs(t0)) t0++;
      if (t0 > n_cyc) break;
      ts = t0 + H;
      if (rs(ts)) begin
        mark_busy(t0 + 1, ts);
        t = ts + 1;
        continue;
      end
      b = '0;
      for (int k = 0; k < 8; k++) b[k] = rs(ts + (k + 1) * CPB);
      sp = ts + 9 * CPB;
      if (rs(sp)) begin
        mark_busy(t0 + 1, sp);
        if (sp + 1 <= n_cyc) begin
          exp_en[sp+1]  = 1'b1;
          ev_byte[sp+1] = b;
        end
        t = sp + 1;
      end else begin
        if (sp + 1 <= n_cyc) exp_fe[sp+1] = 1'b1;
        c = sp + 1;
        while (c <= n_cyc && !rs(c)) c++;
        mark_busy(t0 + 1, c);
        t = c + 1;
      end
    end
    cur = 8'h00;
    for (int k = 0; k <= n_cyc; k++) begin
      if (exp_en[k]) cur = ev_byte[k];
      exp_data[k] = cur;
    end
  endfunction

  // Per-segment observations.
  int         seg_en, seg_fe, seg_first_en, seg_busy_gap;
  logic [7:0] seg_bytes[$];
  logic [7:0] seg_reg_at_en, seg_reg_after_en;

  function automatic logic [31:0] seg_byte(int i);
    if (i < seg_bytes.size()) return {24'h0, seg_bytes[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic run_segment(input string name, input int limit);
    int mism, first_bad, last, last_en;
    bit seen_busy, prev_en;
    logic [10:0] act, expv, bad_act, bad_exp;
    int gap_q[$];
    build_model();
    last = (limit > 0 && limit < n_cyc) ? limit : n_cyc;
    @(negedge clock);
    rx = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    check({name, " reset outputs"}, {13'h0, data, enable, frame_error, busy, reg_q}, 32'h0);
    reset_n = 1'b1;
    seg_en = 0; seg_fe = 0; seg_first_en = -1; seg_busy_gap = 0;
    seg_bytes.delete();
    seg_reg_at_en = 8'hEE; seg_reg_after_en = 8'hEE;
    mism = 0; first_bad = -1; last_en = -1;
    seen_busy = 1'b0; prev_en = 1'b0;
    bad_act = '0; bad_exp = '0;
    for (int k = 0; k <= last; k++) begin
      act  = {enable, frame_error, busy, data};
      expv = {exp_en[k], exp_fe[k], exp_busy[k], exp_data[k]};
      if (act !== expv) begin
        if (mism == 0) begin first_bad = k; bad_act = act; bad_exp = expv; end
        mism++;
      end
      if (prev_en) seg_reg_after_en = reg_q;
      if (enable) begin
        if (seg_first_en < 0) begin seg_first_en = k; seg_reg_at_en = reg_q; end
        seg_en++;
        last_en = k;
        seg_bytes.push_back(data);
      end
      if (frame_error) seg_fe++;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy && !enable) gap_q.push_back(k);
      prev_en = enable;
      if (k < last) begin
        rx = wq[k];
        @(posedge clock);
        @(negedge clock);
      end
    end
    foreach (gap_q[i]) if (gap_q[i] < last_en) seg_busy_gap++;
    n_checks++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL %s trace: %0d cycles differ, first at cycle %0d: got en/fe/busy/data=%b/%b/%b/%h, expected %b/%b/%b/%h",
               name, mism, first_bad, bad_act[10], bad_act[9], bad_act[8], bad_act[7:0],
               bad_exp[10], bad_exp[9], bad_exp[8], bad_exp[7:0]);
    end
  endtask

  // Table-driven frames, applied back to back on one continuous run.
  typedef struct {
    logic [7:0] byte_v;
    bit         stop_ok;
    int         hold_low;
    logic [7:0] exp_data;
    int         exp_en;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];
  int   tv_en, tv_fe;

  task automatic drive_level(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v;
      @(posedge clock);
      @(negedge clock);
      if (enable)      tv_en++;
      if (frame_error) tv_fe++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop);
    drive_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_level(b[i], CPB);
    drive_level(stop, CPB);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rstop;
    string      nm;

    vecs[0] = '{8'h5A, 1'b1, 0,  8'h5A, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 0,  8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0,  8'hFF, 1, 0};
    vecs[3] = '{8'h81, 1'b1, 0,  8'h81, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 40, 8'h81, 0, 1};
    vecs[5] = '{8'h11, 1'b1, 0,  8'h11, 1, 0};
    vecs[6] = '{8'hC3, 1'b1, 0,  8'hC3, 1, 0};
    vecs[7] = '{8'hA5, 1'b0, 0,  8'hC3, 0, 1};

    reset_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clock);
    check("table reset", {15'h0, data, enable, frame_error, busy}, 32'h0);
    reset_n = 1'b1;
    drive_level(1'b1, 4);
    for (int i = 0; i < 8; i++) begin
      tv_en = 0;
      tv_fe = 0;
      drive_frame(vecs[i].byte_v, vecs[i].stop_ok);
      drive_level(1'b0, vecs[i].hold_low);
      drive_level(1'b1, 3 * CPB);
      check($sformatf("vec%0d enable count", i), tv_en, vecs[i].exp_en);
      check($sformatf("vec%0d frame_error count", i), tv_fe, vecs[i].exp_fe);
      check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d register", i), reg_q, vecs[i].exp_data);
      check($sformatf("vec%0d busy idle", i), busy, 0);
    end

    // Single good frame with exact enable timing.
    wq.delete();
    add_level(1'b1, 5); add_frame(8'h5A, 1'b1); add_level(1'b1, 40);
    run_segment("single", 0);
    check("single enable count", seg_en, 1);
    check("single enable cycle", seg_first_en, 5 + 2 + H + 9 * CPB + 1);
    check("single byte", seg_byte(0), 32'h5A);
    check("single frame_error count", seg_fe, 0);

    // Back-to-back frames with no idle between stop and next start.
    wq.delete();
    add_level(1'b1, 5);
    add_frame(8'h00, 1'b1); add_frame(8'hFF, 1'b1); add_frame(8'h81, 1'b1);
    add_level(1'b1, 40);
    run_segment("b2b", 0);
    check("b2b enable count", seg_en, 3);
    check("b2b byte0", seg_byte(0), 32'h00);
    check("b2b byte1", seg_byte(1), 32'hFF);
    check("b2b byte2", seg_byte(2), 32'h81);
    check("b2b frame_error count", seg_fe, 0);

    // Short low glitch, then a real frame.
    wq.delete();
    add_level(1'b1, 5); add_level(1'b0, 4); add_level(1'b1, 20);
    add_frame(8'h3C, 1'b1); add_level(1'b1, 40);
    run_segment("glitch", 0);
    check("glitch enable count", seg_en, 1);
    check("glitch frame_error count", seg_fe, 0);
    check("glitch byte", seg_byte(0), 32'h3C);
    check("glitch busy dropped", seg_busy_gap > 0, 1);

    // Framing error followed by a held-low line.
    wq.delete();
    add_level(1'b1, 5); add_frame(8'h11, 1'b1); add_frame(8'h3C, 1'b0);
    add_level(1'b0, 40); add_level(1'b1, 40);
    run_segment("ferr", 0);
    check("ferr enable count", seg_en, 1);
    check("ferr frame_error count", seg_fe, 1);
    check("ferr data held", data, 8'h11);

    // Reset asserted after three data bits, then a full frame.
    wq.delete();
    add_level(1'b1, 5); add_frame(8'hA5, 1'b1);
    run_segment("midreset pre", 7 + H + 3 * CPB + 3);
    check("midreset busy before", busy, 1);
    #2 reset_n = 1'b0;
    #1 check("midreset outputs", {15'h0, data, enable, frame_error, busy}, 32'h0);
    check("midreset no enable", seg_en, 0);
    wq.delete();
    add_level(1'b1, 5); add_frame(8'hA5, 1'b1); add_level(1'b1, 40);
    run_segment("midreset post", 0);
    check("midreset enable count", seg_en, 1);
    check("midreset data", data, 8'hA5);

    // Register integration: update on the edge after enable, hold through an error.
    wq.delete();
    add_level(1'b1, 5); add_frame(8'hC3, 1'b1); add_level(1'b1, 10);
    add_frame(8'h5A, 1'b0); add_level(1'b0, 10); add_level(1'b1, 40);
    run_segment("reg", 0);
    check("reg before edge", seg_reg_at_en, 8'h00);
    check("reg after edge", seg_reg_after_en, 8'hC3);
    check("reg frame_error count", seg_fe, 1);
    check("reg held", reg_q, 8'hC3);

    // Random waveforms against the timeline model.
    for (int s = 0; s < 3; s++) begin
      wq.delete();
      add_level(1'b1, $urandom_range(3, 10));
      for (int e = 0; e < 8; e++) begin
        if ($urandom_range(0, 9) == 0) begin
          add_level(1'b0, $urandom_range(1, H - 2));
          add_level(1'b1, $urandom_range(H, 2 * CPB));
        end else begin
          rb    = 8'($urandom);
          rstop = ($urandom_range(0, 3) != 0);
          add_frame(rb, rstop);
          if (!rstop) add_level(1'b0, $urandom_range(0, 30));
          add_level(1'b1, $urandom_range(0, 20));
        end
      end
      add_level(1'b1, 3 * CPB);
      nm = $sformatf("random%0d", s);
      run_segment(nm, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
